pipelined_alu: RTL

Parametrised, registered successor to the team's 4-bit combinational ALU. Operands are WIDTH bits and results are 2*WIDTH bits. Operations are accepted through a valid/ready handshake; most complete in one cycle, while multiply runs as a multi-cycle shift-add sequence. It sits between an operand-issuing controller and a result consumer that may apply backpressure.

---
 rtl/pipelined_alu.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/pipelined_alu.sv
// Registered ALU: WIDTH-bit operands, 2*WIDTH-bit result, valid/ready on both sides, shift-add multiply.
// Optional Zero/Carry flag outputs are built only when ALU_FLAGS_EN is defined.
//
// state | meaning
// IDLE  | no result pending, ready for an operation
// MUL   | shift-add multiply in progress, one partial product per cycle
// HOLD  | ALUout holds a result waiting for the consumer
module pipelined_alu #(
  parameter int WIDTH = 4
) (
  input  logic               Clock,
  input  logic               Resetn,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [2:0]         Function,
  input  logic               InValid,
  output logic               InReady,
  output logic [2*WIDTH-1:0] ALUout,
  output logic               OutValid,
  input  logic               OutReady,
  output logic               Busy
`ifdef ALU_FLAGS_EN
  ,
  output logic               Zero,
  output logic               Carry
`endif
);

  localparam int W2 = 2 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] FN_ADD    = 3'd0;
  localparam logic [2:0] FN_OR     = 3'd1;
  localparam logic [2:0] FN_AND    = 3'd2;
  localparam logic [2:0] FN_CONCAT = 3'd3;
  localparam logic [2:0] FN_SUB    = 3'd4;
  localparam logic [2:0] FN_MUL    = 3'd5;
  localparam logic [2:0] FN_XOR    = 3'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [W2-1:0]    mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [W2-1:0]    acc_q;
  logic [CW-1:0]    cnt_q;
  logic [W2-1:0]    acc_next;
  logic [W2-1:0]    op_result;
  logic             accept;
  logic             is_mul;
  logic             mul_done;

  assign InReady  = (state_q == IDLE) || ((state_q == HOLD) && OutReady);
  assign accept   = InValid && InReady;
  assign is_mul   = (Function == FN_MUL);
  assign mul_done = (state_q == MUL) && (cnt_q == '0);
  assign OutValid = (state_q == HOLD);
  assign Busy     = (state_q == MUL);

  // Final step folds its partial product straight into ALUout.
  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    op_result = '0;
    case (Function)
      FN_ADD:    op_result = W2'(A) + W2'(B);
      FN_OR:     op_result = W2'(|{A, B});
      FN_AND:    op_result = W2'(&{A, B});
      FN_CONCAT: op_result = {A, B};
      FN_SUB:    op_result = W2'(A) - W2'(B);
      FN_XOR:    op_result = W2'(A ^ B);
      default:   op_result = '0;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = is_mul ? MUL : HOLD;
      end
      MUL: begin
        if (mul_done) state_d = HOLD;
      end
      HOLD: begin
        if (accept)        state_d = is_mul ? MUL : HOLD;
        else if (OutReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      ALUout   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (accept && !is_mul) begin
      ALUout <= op_result;
    end else if (accept) begin
      mcand_q  <= W2'(A);
      mplier_q <= B;
      acc_q    <= '0;
      cnt_q    <= CW'(WIDTH - 1);
    end else if (state_q == MUL) begin
      if (mul_done) begin
        ALUout <= acc_next;
      end else begin
        acc_q    <= acc_next;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q - CW'(1);
      end
    end
  end

`ifdef ALU_FLAGS_EN
  logic carry_next;

  always_comb begin
    carry_next = 1'b0;
    case (Function)
      FN_ADD:  carry_next = op_result[WIDTH];
      FN_SUB:  carry_next = (A < B);
      default: carry_next = 1'b0;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      Zero  <= 1'b0;
      Carry <= 1'b0;
    end else if (accept && !is_mul) begin
      Zero  <= (op_result == '0);
      Carry <= carry_next;
    end else if (mul_done) begin
      Zero  <= (acc_next == '0);
      Carry <= 1'b0;
    end
  end
`endif

endmodule
